// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between eight requesters and the shared-mux arbiter.
// master: requester side; slave: arbiter side.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output busy,
    output timeout
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 mux: one grant at a time, bounded hold time,
// and a mandatory idle cycle between grants.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic              clk,
  input logic              rst,
  mux8_rr_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e      state_q, state_d;
  logic [7:0]  gnt_q, gnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic [2:0]  last_q, last_d;
  logic [2:0]  owner_q, owner_d;
  logic [7:0]  hcnt_q, hcnt_d;

  logic        found;
  logic [2:0]  winner;
  logic [2:0]  cand;
  logic        hold_hit;

  // Circular scan starting just after the previous grantee; k == 8 wraps back to last_q.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    cand   = '0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_q + 3'(k);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign hold_hit = (MAX_HOLD != 0) && (hcnt_q == 8'(MAX_HOLD));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    owner_d   = owner_q;
    hcnt_d    = hcnt_q;
    unique case (state_q)
      StIdle: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (found) begin
          state_d = StGrant;
          gnt_d   = 8'b1 << winner;
          // Mux select is bit-reversed: sel[0] carries the index MSB.
          sel_d   = {winner[0], winner[1], winner[2]};
          busy_d  = 1'b1;
          owner_d = winner;
          last_d  = winner;
          hcnt_d  = 8'd1;
        end
      end
      StGrant: begin
        if (!bus.req[owner_q] || hold_hit) begin
          state_d   = StIdle;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = bus.req[owner_q];
        end else if (hcnt_q != 8'hFF) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= 3'd7;
      owner_q   <= '0;
      hcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      hcnt_q    <= hcnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: four instances (MAX_HOLD 16/2/3/0) share one req stream and are
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;

  always #5 clk = ~clk;

  mux8_rr_arbiter_if if0 ();
  mux8_rr_arbiter_if if1 ();
  mux8_rr_arbiter_if if2 ();
  mux8_rr_arbiter_if if3 ();

  assign if0.req = req;
  assign if1.req = req;
  assign if2.req = req;
  assign if3.req = req;

  mux8_rr_arbiter #(.MAX_HOLD(16)) u0 (.clk(clk), .rst(rst), .bus(if0));
  mux8_rr_arbiter #(.MAX_HOLD(2))  u1 (.clk(clk), .rst(rst), .bus(if1));
  mux8_rr_arbiter #(.MAX_HOLD(3))  u2 (.clk(clk), .rst(rst), .bus(if2));
  mux8_rr_arbiter #(.MAX_HOLD(0))  u3 (.clk(clk), .rst(rst), .bus(if3));

  logic [7:0] dgnt [4];
  logic [2:0] dsel [4];
  logic       dbusy[4];
  logic       dto  [4];

  assign dgnt[0] = if0.gnt;  assign dsel[0] = if0.sel;  assign dbusy[0] = if0.busy;
  assign dto[0]  = if0.timeout;
  assign dgnt[1] = if1.gnt;  assign dsel[1] = if1.sel;  assign dbusy[1] = if1.busy;
  assign dto[1]  = if1.timeout;
  assign dgnt[2] = if2.gnt;  assign dsel[2] = if2.sel;  assign dbusy[2] = if2.busy;
  assign dto[2]  = if2.timeout;
  assign dgnt[3] = if3.gnt;  assign dsel[3] = if3.sel;  assign dbusy[3] = if3.busy;
  assign dto[3]  = if3.timeout;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the mux, for how many cycles, and whom to favour next.
  int         hold_v[4] = '{16, 2, 3, 0};
  int         m_owner[4];
  int         m_age[4];
  int         m_last[4];
  logic [2:0] m_sel[4];
  logic       m_to[4];
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_owner[i] = -1;
        m_age[i]   = 0;
        m_last[i]  = 7;
        m_sel[i]   = 3'b000;
        m_to[i]    = 1'b0;
      end else if (m_owner[i] >= 0) begin
        m_to[i] = 1'b0;
        if (!req[m_owner[i]]) begin
          m_owner[i] = -1;
        end else if (hold_v[i] != 0 && m_age[i] >= hold_v[i]) begin
          m_owner[i] = -1;
          m_to[i]    = 1'b1;
        end else begin
          m_age[i]++;
        end
      end else begin
        m_to[i] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
          if (m_owner[i] < 0 && req[(m_last[i] + k) % 8]) m_owner[i] = (m_last[i] + k) % 8;
        end
        if (m_owner[i] >= 0) begin
          m_last[i]   = m_owner[i];
          m_age[i]    = 1;
          m_sel[i][0] = 1'((m_owner[i] / 4) % 2);
          m_sel[i][1] = 1'((m_owner[i] / 2) % 2);
          m_sel[i][2] = 1'(m_owner[i] % 2);
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  int         q1[$];
  logic [7:0] prev_gnt1 = 8'h00;

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 4; i++) begin
        logic [7:0] eg;
        eg = (m_owner[i] >= 0) ? 8'(1 << m_owner[i]) : 8'h00;
        check($sformatf("model_gnt%0d", i), 32'(dgnt[i]), 32'(eg));
        check($sformatf("model_sel%0d", i), 32'(dsel[i]), 32'(m_sel[i]));
        check($sformatf("model_busy%0d", i), 32'(dbusy[i]), 32'(eg != 8'h00));
        check($sformatf("model_timeout%0d", i), 32'(dto[i]), 32'(m_to[i]));
        check($sformatf("onehot0_%0d", i), 32'($onehot0(dgnt[i])), 32'd1);
      end
      if (prev_gnt1 == 8'h00 && dgnt[1] != 8'h00) begin
        for (int b = 0; b < 8; b++) if (dgnt[1][b]) q1.push_back(b);
      end
      prev_gnt1 = dgnt[1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int         cnt, cnt_to;
  logic [9:0] busy_v, to_v;
  bit         sel_ok;

  initial begin
    // Reset then single request
    rst = 1'b1; req = 8'h00;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check("rst_gnt", 32'(dgnt[i]), 32'h0);
      check("rst_sel", 32'(dsel[i]), 32'h0);
      check("rst_busy", 32'(dbusy[i]), 32'h0);
    end
    rst = 1'b0;
    req = 8'h20; cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) begin
        check("t1_gnt", 32'(dgnt[0]), 32'h20);
        check("t1_sel", 32'(dsel[0]), 32'b101);
      end
      if (dbusy[0]) cnt++;
      check("t1_no_timeout", 32'(dto[0]), 32'h0);
    end
    req = 8'h00;
    tick();
    check("t1_busy_cycles", 32'(cnt), 32'd4);
    check("t1_released", 32'(dgnt[0]), 32'h0);
    check("t1_sel_holds", 32'(dsel[0]), 32'b101);
    tick();

    // Priority after a grant to index 5
    req = 8'h21;
    tick();
    check("t3_first_idx0", 32'(dgnt[0]), 32'h01);
    check("t3_sel0", 32'(dsel[0]), 32'b000);
    req = 8'h20;
    tick();
    check("t3_gap", 32'(dgnt[0]), 32'h00);
    tick();
    check("t3_then_idx5", 32'(dgnt[0]), 32'h20);
    req = 8'h00;
    tick(); tick();

    // Rotation with MAX_HOLD=2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q1.delete();
    req = 8'hFF; cnt = 0; cnt_to = 0;
    for (int c = 0; c < 27; c++) begin
      tick();
      if (dbusy[1]) cnt++;
      if (dto[1]) cnt_to++;
    end
    req = 8'h00;
    tick(); tick();
    check("t2_grant_count", 32'(q1.size()), 32'd9);
    for (int g = 0; g < 9 && g < q1.size(); g++) begin
      check($sformatf("t2_order%0d", g), 32'(q1[g]), 32'(g % 8));
    end
    check("t2_busy_cycles", 32'(cnt), 32'd18);
    check("t2_timeouts", 32'(cnt_to), 32'd9);

    // Lone requester with MAX_HOLD=3
    req = 8'h04; sel_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      busy_v[c] = dbusy[2];
      to_v[c]   = dto[2];
      if (dsel[2] != 3'b010) sel_ok = 1'b0;
    end
    req = 8'h00;
    tick(); tick();
    check("t4_busy_pattern", 32'(busy_v), 32'(10'b1101110111));
    check("t4_timeout_pattern", 32'(to_v), 32'(10'b0010001000));
    check("t4_sel_constant", 32'(sel_ok), 32'd1);

    // Reset mid-grant
    req = 8'h80;
    tick();
    check("t5_gnt7", 32'(dgnt[0]), 32'h80);
    tick();
    check("t5_gnt7_hold", 32'(dgnt[0]), 32'h80);
    rst = 1'b1;
    tick();
    check("t5_rst_gnt", 32'(dgnt[0]), 32'h00);
    check("t5_rst_sel", 32'(dsel[0]), 32'h0);
    check("t5_rst_busy", 32'(dbusy[0]), 32'h0);
    rst = 1'b0; req = 8'h81;
    tick();
    check("t5_idx0_first", 32'(dgnt[0]), 32'h01);
    req = 8'h00;
    tick(); tick();

    // MAX_HOLD=0: unbounded hold, counter saturates
    req = 8'h02; cnt = 0; cnt_to = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (dgnt[3] == 8'h02) cnt++;
      if (dto[3]) cnt_to++;
    end
    check("t6_hcnt_sat", 32'(u3.hcnt_q), 32'd255);
    req = 8'h00;
    tick();
    check("t6_granted_cycles", 32'(cnt), 32'd300);
    check("t6_no_timeout", 32'(cnt_to), 32'd0);
    check("t6_released", 32'(dgnt[3]), 32'h00);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
